// File: rtl/uart_rx_ctrl.sv
// RX-domain controller for the uArtRx receiver: quiet-line baud switching, show-ahead byte FIFO, overrun flag.
// Optional stale-data timeout is built when FRAME_TIMEOUT_EN is defined; otherwise timeout is tied to 0.
module uart_rx_ctrl #(
  parameter int         DEPTH          = 4,
  parameter logic [1:0] DEFAULT_BAUD   = 2'd3,
  parameter int         IDLE_CYCLES    = 16,
  parameter int         RST_CYCLES     = 2,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                   clkRx,
  input  logic                   reset,
  input  logic                   serialInput,
  input  logic                   rxBusy,
  input  logic                   rxByteValid,
  input  logic [7:0]             rxData,
  output logic [1:0]             baudRate,
  output logic                   rxReset,
  input  logic                   cfgWrite,
  input  logic [1:0]             cfgBaud,
  output logic                   cfgPending,
  output logic                   outValid,
  output logic [7:0]             outData,
  input  logic                   outReady,
  output logic [$clog2(DEPTH):0] fifoCount,
  output logic                   overrun,
  input  logic                   clearErr,
  output logic                   timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(IDLE_CYCLES) + 1;
  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (IDLE_CYCLES < 1) ||
      (RST_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
    $error("uart_rx_ctrl: illegal parameter value");
  end

  typedef enum logic [1:0] {RUN, PEND, SWITCH} state_e;

  state_e        state_q;
  logic [1:0]    baud_q, pend_q;
  logic          rx_rst_q, cfg_pend_q, sw_req_q;
  logic [IW-1:0] idle_q;
  logic [RW-1:0] rst_cnt_q;
  logic          quiet;

  assign quiet = serialInput && !rxBusy;

  always_ff @(posedge clkRx or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      baud_q     <= DEFAULT_BAUD;
      pend_q     <= DEFAULT_BAUD;
      rx_rst_q   <= 1'b0;
      cfg_pend_q <= 1'b0;
      sw_req_q   <= 1'b0;
      idle_q     <= '0;
      rst_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (cfgWrite && (cfgBaud != baud_q)) begin
            pend_q     <= cfgBaud;
            cfg_pend_q <= 1'b1;
            idle_q     <= '0;
            state_q    <= PEND;
          end
        end
        PEND: begin
          if (cfgWrite && (cfgBaud == baud_q)) begin
            cfg_pend_q <= 1'b0;
            idle_q     <= '0;
            state_q    <= RUN;
          end else begin
            if (cfgWrite) pend_q <= cfgBaud;
            if (!quiet) begin
              idle_q <= '0;
            end else if (idle_q == IDLE_LAST) begin
              // A write landing on the switch cycle is the one applied.
              baud_q    <= cfgWrite ? cfgBaud : pend_q;
              rx_rst_q  <= 1'b1;
              rst_cnt_q <= '0;
              idle_q    <= '0;
              sw_req_q  <= 1'b0;
              state_q   <= SWITCH;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
        end
        SWITCH: begin
          if (cfgWrite) pend_q <= cfgBaud;
          if (rst_cnt_q == RST_LAST) begin
            rx_rst_q <= 1'b0;
            idle_q   <= '0;
            sw_req_q <= 1'b0;
            if ((cfgWrite || sw_req_q) && ((cfgWrite ? cfgBaud : pend_q) != baud_q)) begin
              cfg_pend_q <= 1'b1;
              state_q    <= PEND;
            end else begin
              cfg_pend_q <= 1'b0;
              state_q    <= RUN;
            end
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
            if (cfgWrite) sw_req_q <= 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign baudRate   = baud_q;
  assign rxReset    = rx_rst_q;
  assign cfgPending = cfg_pend_q;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          ovr_q;
  logic          full, push_req, push, pop;

  assign full     = (cnt_q == FULL_CNT);
  assign push_req = rxByteValid && (state_q != SWITCH);
  assign pop      = outValid && outReady;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a byte.
  assign push     = push_req && (!full || pop);

  assign outValid  = (cnt_q != '0);
  assign outData   = outValid ? mem_q[rd_q] : 8'h00;
  assign fifoCount = cnt_q;
  assign overrun   = ovr_q;

  always_ff @(posedge clkRx) begin
    if (push) mem_q[wr_q] <= rxData;
  end

  always_ff @(posedge clkRx or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      if (push_req && full && !pop) ovr_q <= 1'b1;
      else if (clearErr)            ovr_q <= 1'b0;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt_q;
  logic          tout_q;

  always_ff @(posedge clkRx or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
      tout_q <= 1'b0;
    end else if (push || pop || !outValid) begin
      tcnt_q <= '0;
      tout_q <= 1'b0;
    end else begin
      if (tcnt_q != TO_LAST) tcnt_q <= tcnt_q + 1'b1;
      tout_q <= (tcnt_q == TO_LAST) || ((tcnt_q + 1'b1) == TO_LAST);
    end
  end

  assign timeout = tout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: table-driven FIFO vectors plus hand-written baud-switch and reset sequences.
module tb_uart_rx_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       serialInput, rxBusy, rxByteValid;
  logic [7:0] rxData;
  logic [1:0] baudRate;
  logic       rxReset;
  logic       cfgWrite;
  logic [1:0] cfgBaud;
  logic       cfgPending, outValid;
  logic [7:0] outData;
  logic       outReady;
  logic [2:0] fifoCount;
  logic       overrun, clearErr, timeout;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(
    .DEPTH(4), .DEFAULT_BAUD(2'd3), .IDLE_CYCLES(16), .RST_CYCLES(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clkRx(clk), .reset(reset), .serialInput(serialInput), .rxBusy(rxBusy),
    .rxByteValid(rxByteValid), .rxData(rxData), .baudRate(baudRate), .rxReset(rxReset),
    .cfgWrite(cfgWrite), .cfgBaud(cfgBaud), .cfgPending(cfgPending), .outValid(outValid),
    .outData(outData), .outReady(outReady), .fifoCount(fifoCount), .overrun(overrun),
    .clearErr(clearErr), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rxv;
    logic [7:0] din;
    logic       rdy;
    logic       clr;
    logic [2:0] cnt;
    logic       vld;
    logic [7:0] dout;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rxv, input logic [7:0] din, input logic rdy, input logic clr,
                     input logic [2:0] cnt, input logic vld, input logic [7:0] dout, input logic ovr);
    vec_t v;
    v.rxv = rxv; v.din = din; v.rdy = rdy; v.clr = clr;
    v.cnt = cnt; v.vld = vld; v.dout = dout; v.ovr = ovr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic saw_rst;

    reset = 1'b1; serialInput = 1'b1; rxBusy = 1'b0; rxByteValid = 1'b0; rxData = 8'h00;
    cfgWrite = 1'b0; cfgBaud = 2'd0; outReady = 1'b0; clearErr = 1'b0;

    // Stimulus table: inputs | expected count, valid, head, overrun after the edge
    add(1'b1, 8'hA5, 1'b0, 1'b0, 3'd1, 1'b1, 8'hA5, 1'b0);
    add(1'b1, 8'h3C, 1'b0, 1'b0, 3'd2, 1'b1, 8'hA5, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 1'b0, 3'd3, 1'b1, 8'hA5, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h3C, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'hFF, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'h11, 1'b0, 1'b0, 3'd1, 1'b1, 8'h11, 1'b0);
    add(1'b1, 8'h22, 1'b0, 1'b0, 3'd2, 1'b1, 8'h11, 1'b0);
    add(1'b1, 8'h33, 1'b0, 1'b0, 3'd3, 1'b1, 8'h11, 1'b0);
    add(1'b1, 8'h44, 1'b0, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0);
    add(1'b1, 8'h55, 1'b0, 1'b0, 3'd4, 1'b1, 8'h11, 1'b1);
    add(1'b1, 8'h66, 1'b1, 1'b0, 3'd4, 1'b1, 8'h22, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1, 8'h22, 1'b0);
    add(1'b1, 8'h77, 1'b0, 1'b1, 3'd4, 1'b1, 8'h22, 1'b1);
    add(1'b0, 8'h00, 1'b0, 1'b1, 3'd4, 1'b1, 8'h22, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 8'h33, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 8'h44, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 8'h66, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'h88, 1'b1, 1'b0, 3'd1, 1'b1, 8'h88, 1'b0);
    add(1'b1, 8'h99, 1'b1, 1'b0, 3'd1, 1'b1, 8'h99, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    chk("rst_baud", baudRate, 2'd3);
    chk("rst_cfgpend", cfgPending, 1'b0);
    chk("rst_rxreset", rxReset, 1'b0);
    chk("rst_count", fifoCount, 3'd0);
    chk("rst_valid", outValid, 1'b0);
    chk("rst_data", outData, 8'h00);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    reset = 1'b0;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      rxByteValid = tbl[i].rxv; rxData = tbl[i].din;
      outReady = tbl[i].rdy; clearErr = tbl[i].clr;
      step();
      chk($sformatf("v%0d_count", i), fifoCount, tbl[i].cnt);
      chk($sformatf("v%0d_valid", i), outValid, tbl[i].vld);
      chk($sformatf("v%0d_data", i), outData, tbl[i].dout);
      chk($sformatf("v%0d_overrun", i), overrun, tbl[i].ovr);
    end
    rxByteValid = 1'b0; rxData = 8'h00; outReady = 1'b0; clearErr = 1'b0;

    // Same-baud write ignored; pending change cancelled by writing the current baud back
    cfgWrite = 1'b1; cfgBaud = 2'd3; step(); cfgWrite = 1'b0;
    chk("same_baud_ignored", cfgPending, 1'b0);
    cfgWrite = 1'b1; cfgBaud = 2'd1; step(); cfgWrite = 1'b0;
    chk("cancel_pending_set", cfgPending, 1'b1);
    repeat (3) step();
    cfgWrite = 1'b1; cfgBaud = 2'd3; step(); cfgWrite = 1'b0;
    chk("cancel_pending_clr", cfgPending, 1'b0);
    saw_rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rxReset === 1'b1) saw_rst = 1'b1;
    end
    chk("cancel_no_rxreset", saw_rst, 1'b0);
    chk("cancel_baud", baudRate, 2'd3);

    // Baud switch after 16 quiet cycles, bytes discarded during the reset pulse
    cfgWrite = 1'b1; cfgBaud = 2'd0; step(); cfgWrite = 1'b0;
    chk("sw_pending", cfgPending, 1'b1);
    chk("sw_baud_before", baudRate, 2'd3);
    n = 0;
    while (rxReset !== 1'b1 && n < 40) begin step(); n++; end
    chk("sw_quiet_cycles", n, 16);
    chk("sw_baud_after", baudRate, 2'd0);
    rxByteValid = 1'b1; rxData = 8'h5A;
    step();
    chk("sw_rxreset_cycle2", rxReset, 1'b1);
    chk("sw_pending_during", cfgPending, 1'b1);
    step();
    rxByteValid = 1'b0;
    chk("sw_rxreset_end", rxReset, 1'b0);
    chk("sw_pending_end", cfgPending, 1'b0);
    chk("sw_no_push", fifoCount, 3'd0);
    chk("sw_no_overrun", overrun, 1'b0);

    // Last write wins; a line drop at idle count 10 restarts the count
    cfgWrite = 1'b1; cfgBaud = 2'd1; step();
    cfgBaud = 2'd2; step(); cfgWrite = 1'b0;
    repeat (9) step();
    serialInput = 1'b0; step(); serialInput = 1'b1;
    chk("drop_no_switch", baudRate, 2'd0);
    n = 0;
    while (rxReset !== 1'b1 && n < 40) begin step(); n++; end
    chk("drop_restart_cycles", n, 16);
    chk("drop_last_write_baud", baudRate, 2'd2);
    repeat (2) step();
    chk("drop_rxreset_end", rxReset, 1'b0);
    chk("drop_pending_end", cfgPending, 1'b0);

    // Reset in the middle of a pending change
    cfgWrite = 1'b1; cfgBaud = 2'd1; step(); cfgWrite = 1'b0;
    rxByteValid = 1'b1; rxData = 8'hC3; step(); rxByteValid = 1'b0;
    repeat (4) step();
    chk("midpend_count_pre", fifoCount, 3'd1);
    chk("midpend_pending_pre", cfgPending, 1'b1);
    reset = 1'b1;
    #2;
    chk("midpend_baud", baudRate, 2'd3);
    chk("midpend_pending", cfgPending, 1'b0);
    chk("midpend_count", fifoCount, 3'd0);
    chk("midpend_valid", outValid, 1'b0);
    chk("midpend_data", outData, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    saw_rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rxReset === 1'b1) saw_rst = 1'b1;
    end
    chk("midpend_discarded", saw_rst, 1'b0);
    chk("midpend_baud_hold", baudRate, 2'd3);

`ifdef FRAME_TIMEOUT_EN
    rxByteValid = 1'b1; rxData = 8'hE7; step(); rxByteValid = 1'b0;
    n = 1;
    while (timeout !== 1'b1 && n < 30) begin step(); n++; end
    chk("timeout_cycles", n, 8);
    chk("timeout_count", fifoCount, 3'd1);
    outReady = 1'b1; step(); outReady = 1'b0;
    chk("timeout_clear", timeout, 1'b0);
    chk("timeout_popped", fifoCount, 3'd0);
`else
    rxByteValid = 1'b1; rxData = 8'hE7; step(); rxByteValid = 1'b0;
    repeat (20) step();
    chk("timeout_tied_low", timeout, 1'b0);
    chk("timeout_held_head", outData, 8'hE7);
    outReady = 1'b1; step(); outReady = 1'b0;
    chk("timeout_popped", fifoCount, 3'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
